ifetch_stage: RTL and testbench



---
 rtl/ifetch_stage.sv | 106 ++++++++++
 tb/tb_ifetch_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: reads one word per fetch over a 4-phase req/ack memory
// handshake and pushes it into the instruction queue over a 4-phase we/w_ack handshake.
module ifetch_stage #(
   parameter int unsigned     PC_W     = 64,
   parameter int unsigned     DATA_L   = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [PC_W-1:0] PC_INC   = PC_W'(4)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              mem_re,
   output logic [PC_W-1:0]   mem_addr,
   input  logic [DATA_L-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              buf_we,
   output logic [DATA_L-1:0] buf_din,
   input  logic              buf_w_ack,
   input  logic              buf_full,
   output logic [PC_W-1:0]   pc,
   output logic [31:0]       fetch_cnt
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] MEM_REQ  = 3'd1;
   localparam logic [2:0] MEM_REL  = 3'd2;
   localparam logic [2:0] BUF_WAIT = 3'd3;
   localparam logic [2:0] BUF_REQ  = 3'd4;
   localparam logic [2:0] BUF_REL  = 3'd5;

   logic [2:0]      state;
   logic            redir_pend;
   logic [PC_W-1:0] redir_tgt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         mem_re     <= 1'b0;
         buf_we     <= 1'b0;
         mem_addr   <= '0;
         buf_din    <= '0;
         fetch_cnt  <= '0;
         redir_pend <= 1'b0;
         redir_tgt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (redir_pend) begin
                  pc         <= redir_tgt;
                  redir_pend <= 1'b0;
               end else if (!stall) begin
                  mem_addr <= pc;
                  mem_re   <= 1'b1;
                  state    <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (mem_ack) begin
                  buf_din <= mem_rdata;
                  mem_re  <= 1'b0;
                  state   <= MEM_REL;
               end
            end
            MEM_REL: begin
               if (!mem_ack) state <= redir_pend ? IDLE : BUF_WAIT;
            end
            BUF_WAIT: begin
               if (redir_pend) begin
                  state <= IDLE;
               end else if (!buf_full) begin
                  buf_we <= 1'b1;
                  state  <= BUF_REQ;
               end
            end
            BUF_REQ: begin
               if (buf_w_ack) begin
                  buf_we <= 1'b0;
                  state  <= BUF_REL;
               end
            end
            BUF_REL: begin
               if (!buf_w_ack) begin
                  fetch_cnt <= fetch_cnt + 32'd1;
                  // A pending redirect replaces the increment; IDLE loads its target.
                  if (!redir_pend) pc <= pc + PC_INC;
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               mem_re <= 1'b0;
               buf_we <= 1'b0;
            end
         endcase
         // Placed last so a pulse arriving as IDLE consumes the old target still wins.
         if (redirect) begin
            redir_pend <= 1'b1;
            redir_tgt  <= {redirect_pc[PC_W-1:2], 2'b00};
         end
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage with auto-acking memory and queue partners
// and an address/data scoreboard.
module tb_ifetch_stage;
   localparam int unsigned PC_W   = 64;
   localparam int unsigned DATA_L = 32;
   localparam logic [63:0] RST_PC = 64'h100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stall = 1'b1;
   logic              redirect = 1'b0;
   logic [PC_W-1:0]   redirect_pc = '0;
   logic              mem_re;
   logic [PC_W-1:0]   mem_addr;
   logic [DATA_L-1:0] mem_rdata = '0;
   logic              mem_ack = 1'b0;
   logic              buf_we;
   logic [DATA_L-1:0] buf_din;
   logic              buf_w_ack = 1'b0;
   logic              buf_full = 1'b0;
   logic [PC_W-1:0]   pc;
   logic [31:0]       fetch_cnt;

   int total = 0;
   int bad   = 0;
   bit buf_auto = 1'b1;
   logic [63:0] exp_addr [$];
   logic [31:0] exp_data [$];
   logic [63:0] ea;
   logic [31:0] ed;

   ifetch_stage #(
      .PC_W(PC_W),
      .DATA_L(DATA_L),
      .RESET_PC(RST_PC),
      .PC_INC(64'd4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .mem_re(mem_re),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack),
      .buf_we(buf_we),
      .buf_din(buf_din),
      .buf_w_ack(buf_w_ack),
      .buf_full(buf_full),
      .pc(pc),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   // Memory partner: acks shortly after the edge where mem_re is seen, checks the address.
   always @(posedge clk) begin
      #1;
      if (mem_re && !mem_ack) begin
         total++;
         if (exp_addr.size() == 0) begin
            bad++;
            $display("FAIL mem_addr: got unexpected fetch at %h, required none", mem_addr);
         end else begin
            ea = exp_addr.pop_front();
            if (mem_addr !== ea) begin
               bad++;
               $display("FAIL mem_addr: got %h required %h", mem_addr, ea);
            end
         end
         mem_rdata = data_of(mem_addr);
         mem_ack   = 1'b1;
      end else if (!mem_re) begin
         mem_ack = 1'b0;
      end
   end

   // Queue partner: acks buf_we and checks the pushed word against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (buf_auto) begin
         if (buf_we && !buf_w_ack) begin
            total++;
            if (exp_data.size() == 0) begin
               bad++;
               $display("FAIL buf_din: got unexpected push %h, required none", buf_din);
            end else begin
               ed = exp_data.pop_front();
               if (buf_din !== ed) begin
                  bad++;
                  $display("FAIL buf_din: got %h required %h", buf_din, ed);
               end
            end
            buf_w_ack = 1'b1;
         end else if (!buf_we) begin
            buf_w_ack = 1'b0;
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({mem_re, buf_we} !== 2'b00) begin
         bad++; $display("FAIL reset_strobes: got %b required 00", {mem_re, buf_we});
      end
      total++;
      if (pc !== RST_PC) begin bad++; $display("FAIL reset_pc: got %h required %h", pc, RST_PC); end
      total++;
      if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d required 0", fetch_cnt); end
      total++;
      if (mem_addr !== 64'd0 || buf_din !== 32'd0) begin
         bad++; $display("FAIL reset_data: got addr %h din %h required 0 0", mem_addr, buf_din);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_run3();
      int rise [$];
      bit prev = 1'b0;
      bit done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(RST_PC + 64'(4 * i));
         exp_data.push_back(data_of(RST_PC + 64'(4 * i)));
      end
      stall = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (mem_re && !prev) rise.push_back(cyc);
         prev = mem_re;
         if (fetch_cnt == 32'd3) begin done = 1'b1; break; end
      end
      stall = 1'b1;
      total++;
      if (!done) begin bad++; $display("FAIL run3_timeout: got cnt %0d required 3", fetch_cnt); end
      total++;
      if (rise.size() != 3) begin
         bad++; $display("FAIL run3_fetches: got %0d required 3", rise.size());
      end else begin
         total++;
         if (rise[1] - rise[0] != 6 || rise[2] - rise[1] != 6) begin
            bad++; $display("FAIL run3_period: got %0d,%0d required 6,6", rise[1] - rise[0], rise[2] - rise[1]);
         end
      end
      total++;
      if (pc !== 64'h10C) begin bad++; $display("FAIL run3_pc: got %h required 10c", pc); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_full();
      bit we_seen = 1'b0;
      bit done = 1'b0;
      exp_addr.push_back(64'h10C);
      exp_data.push_back(data_of(64'h10C));
      buf_full = 1'b1;
      stall = 1'b0;
      @(negedge clk);
      total++;
      if (mem_re !== 1'b1) begin bad++; $display("FAIL full_start: got mem_re %b required 1", mem_re); end
      stall = 1'b1;
      repeat (13) begin
         @(negedge clk);
         if (buf_we !== 1'b0) we_seen = 1'b1;
      end
      total++;
      if (we_seen) begin bad++; $display("FAIL full_hold: got buf_we 1 required 0"); end
      buf_full = 1'b0;
      @(negedge clk);
      total++;
      if (buf_we !== 1'b1) begin bad++; $display("FAIL full_release: got buf_we %b required 1", buf_we); end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (fetch_cnt == 32'd4) begin done = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!done || pc !== 64'h110) begin
         bad++; $display("FAIL full_end: got cnt %0d pc %h required 4 110", fetch_cnt, pc);
      end
   endtask

   task automatic test_redirect_mem();
      bit hit = 1'b0;
      bit done = 1'b0;
      exp_addr.push_back(64'h110);
      exp_addr.push_back(64'h2000);
      exp_data.push_back(data_of(64'h2000));
      stall = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (mem_re === 1'b1) begin hit = 1'b1; break; end
      end
      total++;
      if (!hit) begin bad++; $display("FAIL redir_mem_start: got mem_re 0 required 1"); end
      redirect_pc = 64'h2003;
      redirect = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (mem_re === 1'b1) begin hit = 1'b1; break; end
      end
      total++;
      if (!hit || mem_addr !== 64'h2000 || fetch_cnt !== 32'd4) begin
         bad++; $display("FAIL redir_mem_next: got addr %h cnt %0d required 2000 4", mem_addr, fetch_cnt);
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (fetch_cnt == 32'd5) begin done = 1'b1; break; end
         @(negedge clk);
      end
      stall = 1'b1;
      total++;
      if (!done || pc !== 64'h2004) begin
         bad++; $display("FAIL redir_mem_end: got cnt %0d pc %h required 5 2004", fetch_cnt, pc);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_redirect_buf();
      bit hit = 1'b0;
      bit done = 1'b0;
      exp_addr.push_back(64'h2004);
      exp_addr.push_back(64'h3000);
      exp_data.push_back(data_of(64'h2004));
      exp_data.push_back(data_of(64'h3000));
      stall = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (buf_we === 1'b1) begin hit = 1'b1; break; end
      end
      total++;
      if (!hit) begin bad++; $display("FAIL redir_buf_start: got buf_we 0 required 1"); end
      redirect_pc = 64'h3000;
      redirect = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (mem_re === 1'b1) begin hit = 1'b1; break; end
      end
      total++;
      if (!hit || mem_addr !== 64'h3000 || fetch_cnt !== 32'd6) begin
         bad++; $display("FAIL redir_buf_next: got addr %h cnt %0d required 3000 6", mem_addr, fetch_cnt);
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (fetch_cnt == 32'd7) begin done = 1'b1; break; end
         @(negedge clk);
      end
      stall = 1'b1;
      total++;
      if (!done || pc !== 64'h3004) begin
         bad++; $display("FAIL redir_buf_end: got cnt %0d pc %h required 7 3004", fetch_cnt, pc);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      bit bad_late = 1'b0;
      buf_auto = 1'b0;
      buf_w_ack = 1'b0;
      exp_addr.push_back(64'h3004);
      stall = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (buf_we === 1'b1) begin hit = 1'b1; break; end
      end
      total++;
      if (!hit) begin bad++; $display("FAIL rst_mid_start: got buf_we 0 required 1"); end
      stall = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (buf_we !== 1'b0 || pc !== RST_PC || fetch_cnt !== 32'd0) begin
         bad++; $display("FAIL rst_mid: got we %b pc %h cnt %0d required 0 %h 0", buf_we, pc, fetch_cnt, RST_PC);
      end
      buf_w_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (buf_we !== 1'b0 || fetch_cnt !== 32'd0 || mem_re !== 1'b0) bad_late = 1'b1;
      end
      buf_w_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (buf_we !== 1'b0 || fetch_cnt !== 32'd0 || mem_re !== 1'b0) bad_late = 1'b1;
      end
      total++;
      if (bad_late) begin
         bad++; $display("FAIL rst_late_ack: got we %b cnt %0d required 0 0", buf_we, fetch_cnt);
      end
      buf_auto = 1'b1;
   endtask

   task automatic test_wrap();
      bit done = 1'b0;
      bit early = 1'b0;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      redirect = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      @(negedge clk);
      total++;
      if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         bad++; $display("FAIL wrap_load: got %h required fffffffffffffffc", pc);
      end
      exp_addr.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_data.push_back(data_of(64'hFFFF_FFFF_FFFF_FFFC));
      repeat (5) begin
         @(negedge clk);
         if (mem_re !== 1'b0) early = 1'b1;
      end
      total++;
      if (early) begin bad++; $display("FAIL wrap_stall: got mem_re 1 required 0"); end
      stall = 1'b0;
      @(negedge clk);
      stall = 1'b1;
      total++;
      if (mem_re !== 1'b1) begin bad++; $display("FAIL wrap_start: got mem_re %b required 1", mem_re); end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (fetch_cnt == 32'd1) begin done = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!done || pc !== 64'd0) begin
         bad++; $display("FAIL wrap_pc: got cnt %0d pc %h required 1 0", fetch_cnt, pc);
      end
      early = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_re !== 1'b0) early = 1'b1;
      end
      total++;
      if (early) begin bad++; $display("FAIL wrap_restall: got mem_re 1 required 0"); end
   endtask

   initial begin
      test_reset();
      test_run3();
      test_full();
      test_redirect_mem();
      test_redirect_buf();
      test_reset_mid();
      test_wrap();
      total++;
      if (exp_addr.size() != 0 || exp_data.size() != 0) begin
         bad++; $display("FAIL scoreboard_left: got %0d addr %0d data required 0 0", exp_addr.size(), exp_data.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
